// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
// Request is held until mem_gnt; read data returns later on mem_rvalid.
interface load_store_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BE_W = DATA_WIDTH / 8;

  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [BE_W-1:0]       mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: issues one load/store per request over req/gnt/rvalid,
// formats load data for writeback and rejects misaligned/illegal accesses.
module load_store_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [4:0]            rd_in,
  output logic                  busy,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [4:0]            rd_out,
  output logic                  store_done,
  output logic                  fault,
  load_store_unit_if.master     bus
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;
  localparam int unsigned RD_W = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                  busy_q, busy_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
  logic [RD_W-1:0]       rd_out_q, rd_out_d;
  logic                  store_done_q, store_done_d;
  logic                  fault_q, fault_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [BE_W-1:0]       mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            off_q, off_d;
  logic [RD_W-1:0]       rd_q, rd_d;

  logic                  reject_c;
  logic [BE_W-1:0]       be_c;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic [DATA_WIDTH-1:0] load_fmt_c;
  logic [7:0]            byte_c;
  logic [15:0]           half_c;

  // Request check: misaligned halves/words, reserved widths, unsigned stores
  always_comb begin
    reject_c = 1'b0;
    if ((funct3[1:0] == 2'b01) && addr[0])            reject_c = 1'b1;
    if ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)) reject_c = 1'b1;
    if ((funct3 == 3'b011) || (funct3[2:1] == 2'b11))  reject_c = 1'b1;
    if (mem_write && funct3[2])                        reject_c = 1'b1;
  end

  // Lane placement of byte enables and replicated store data
  always_comb begin
    be_c    = {BE_W{1'b1}};
    wdata_c = store_data;
    case (funct3[1:0])
      2'b00: begin
        be_c    = BE_W'(4'b0001 << addr[1:0]);
        wdata_c = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_c    = BE_W'(4'b0011 << {addr[1], 1'b0});
        wdata_c = {2{store_data[15:0]}};
      end
      default: begin
        be_c    = {BE_W{1'b1}};
        wdata_c = store_data;
      end
    endcase
    if (!mem_write) wdata_c = '0;
  end

  // Load lane select and extension, using the offset captured at accept
  always_comb begin
    byte_c = bus.mem_rdata[7:0];
    case (off_q)
      2'b00:   byte_c = bus.mem_rdata[7:0];
      2'b01:   byte_c = bus.mem_rdata[15:8];
      2'b10:   byte_c = bus.mem_rdata[23:16];
      default: byte_c = bus.mem_rdata[31:24];
    endcase
    half_c = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_fmt_c = {{(DATA_WIDTH-8){byte_c[7]}}, byte_c};
      3'b001:  load_fmt_c = {{(DATA_WIDTH-16){half_c[15]}}, half_c};
      3'b100:  load_fmt_c = {{(DATA_WIDTH-8){1'b0}}, byte_c};
      3'b101:  load_fmt_c = {{(DATA_WIDTH-16){1'b0}}, half_c};
      default: load_fmt_c = bus.mem_rdata;
    endcase
  end

  // Next-state and next-output decode
  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    store_done_d = 1'b0;
    fault_d      = 1'b0;
    load_data_d  = load_data_q;
    rd_out_d     = rd_out_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    rd_d         = rd_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (reject_c) begin
            fault_d = 1'b1;
          end else begin
            mem_we_d    = mem_write;
            mem_addr_d  = {addr[DATA_WIDTH-1:2], 2'b00};
            mem_be_d    = be_c;
            mem_wdata_d = wdata_c;
            funct3_d    = funct3;
            off_d       = addr[1:0];
            rd_d        = rd_in;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus.mem_gnt) begin
          if (mem_we_q) begin
            store_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.mem_rvalid) begin
          load_data_d  = load_fmt_c;
          rd_out_d     = rd_q;
          resp_valid_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    mem_req_d = (state_d == S_REQ);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      load_data_q  <= '0;
      rd_out_q     <= '0;
      store_done_q <= 1'b0;
      fault_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      funct3_q     <= '0;
      off_q        <= '0;
      rd_q         <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      load_data_q  <= load_data_d;
      rd_out_q     <= rd_out_d;
      store_done_q <= store_done_d;
      fault_q      <= fault_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      rd_q         <= rd_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign busy          = busy_q;
  assign resp_valid    = resp_valid_q;
  assign load_data     = load_data_q;
  assign rd_out        = rd_out_q;
  assign store_done    = store_done_q;
  assign fault         = fault_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, faults, stalls, reset.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic        busy;
  logic        resp_valid;
  logic [31:0] load_data;
  logic [4:0]  rd_out;
  logic        store_done;
  logic        fault;

  int checks;
  int errors;

  load_store_unit_if #(.DATA_WIDTH(32)) bus ();

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .rd_in      (rd_in),
    .busy       (busy),
    .resp_valid (resp_valid),
    .load_data  (load_data),
    .rd_out     (rd_out),
    .store_done (store_done),
    .fault      (fault),
    .bus        (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input logic [4:0] rd);
    req_valid  = 1'b1;
    mem_write  = we;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    rd_in      = rd;
  endtask

  // Runs one load with the given gnt/rvalid wait cycles; lat counts from accept.
  task automatic run_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata,
                          input logic [4:0] rd, input int gnt_wait, input int rv_wait,
                          output int lat, output logic [31:0] data, output logic [4:0] rdo,
                          output logic seen);
    int cyc;
    int n;
    drive_req(1'b0, f3, a, 32'h0, rd);
    step();
    req_valid = 1'b0;
    cyc = 1;
    repeat (gnt_wait) begin step(); cyc++; end
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    cyc++;
    repeat (rv_wait) begin step(); cyc++; end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdata;
    step();
    bus.mem_rvalid = 1'b0;
    cyc++;
    n = 0;
    while (!resp_valid && n < 8) begin step(); cyc++; n++; end
    seen = resp_valid;
    lat  = cyc;
    data = load_data;
    rdo  = rd_out;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; mem_write = 1'b0; funct3 = 3'b0; addr = '0; store_data = '0; rd_in = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    repeat (2) step();
    checks++;
    if ({busy, resp_valid, store_done, fault, bus.mem_req, bus.mem_we} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000",
        {busy, resp_valid, store_done, fault, bus.mem_req, bus.mem_we});
    end
    checks++;
    if ({load_data, rd_out, bus.mem_addr, bus.mem_be, bus.mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_data got ld=%h rd=%h a=%h be=%b wd=%h want zeros",
        load_data, rd_out, bus.mem_addr, bus.mem_be, bus.mem_wdata);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", req_ready);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_load_word();
    drive_req(1'b0, 3'b010, 32'h100, 32'h0, 5'd7);
    step();
    req_valid = 1'b0;
    checks++;
    if ({bus.mem_req, bus.mem_we, busy, req_ready} !== 4'b1010) begin
      errors++; $display("FAIL lw_req_ctrl got %b want 1010", {bus.mem_req, bus.mem_we, busy, req_ready});
    end
    checks++;
    if (bus.mem_addr !== 32'h100 || bus.mem_be !== 4'b1111) begin
      errors++; $display("FAIL lw_req_addr got %h/%b want 00000100/1111", bus.mem_addr, bus.mem_be);
    end
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    checks++;
    if (bus.mem_req !== 1'b0 || busy !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL lw_wait got req=%b busy=%b rv=%b want 0 1 0", bus.mem_req, busy, resp_valid);
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEADBEEF;
    step();
    bus.mem_rvalid = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || load_data !== 32'hDEADBEEF || rd_out !== 5'd7) begin
      errors++; $display("FAIL lw_resp got rv=%b data=%h rd=%0d want 1 deadbeef 7", resp_valid, load_data, rd_out);
    end
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL lw_resp_idle got busy=%b ready=%b want 0 1", busy, req_ready);
    end
    step();
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL lw_pulse got rv=%b want 0", resp_valid);
    end
  endtask

  task automatic test_load_subword();
    logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
    logic [31:0] as  [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100};
    logic [31:0] exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h00000034};
    int lat;
    logic [31:0] data;
    logic [4:0] rdo;
    logic seen;
    for (int i = 0; i < 5; i++) begin
      run_load(f3s[i], as[i], 32'h80FF1234, 5'(i + 1), 0, 0, lat, data, rdo, seen);
      checks++;
      if (!seen || data !== exp[i] || rdo !== 5'(i + 1) || lat != 3) begin
        errors++; $display("FAIL subword_%0d got seen=%b data=%h rd=%0d lat=%0d want 1 %h %0d 3",
          i, seen, data, rdo, lat, exp[i], i + 1);
      end
      step();
    end
  endtask

  task automatic test_store();
    logic [2:0]  f3s [2] = '{3'b000, 3'b001};
    logic [31:0] as  [2] = '{32'h201, 32'h202};
    logic [31:0] sds [2] = '{32'h000000AB, 32'h12345678};
    logic [3:0]  ebe [2] = '{4'b0010, 4'b1100};
    logic [31:0] ewd [2] = '{32'hABABABAB, 32'h56785678};
    for (int i = 0; i < 2; i++) begin
      drive_req(1'b1, f3s[i], as[i], sds[i], 5'd0);
      step();
      req_valid = 1'b0;
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h200 ||
          bus.mem_be !== ebe[i] || bus.mem_wdata !== ewd[i]) begin
        errors++; $display("FAIL store_%0d_req got req=%b we=%b a=%h be=%b wd=%h want 1 1 00000200 %b %h",
          i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata, ebe[i], ewd[i]);
      end
      bus.mem_gnt = 1'b1;
      step();
      bus.mem_gnt = 1'b0;
      checks++;
      if (store_done !== 1'b1 || busy !== 1'b0 || bus.mem_req !== 1'b0 || resp_valid !== 1'b0) begin
        errors++; $display("FAIL store_%0d_done got sd=%b busy=%b req=%b rv=%b want 1 0 0 0",
          i, store_done, busy, bus.mem_req, resp_valid);
      end
      step();
      checks++;
      if (store_done !== 1'b0) begin
        errors++; $display("FAIL store_%0d_pulse got %b want 0", i, store_done);
      end
    end
  endtask

  task automatic test_fault();
    logic        wes [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3s [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
    logic [31:0] as  [4] = '{32'h202, 32'h101, 32'h100, 32'h100};
    for (int i = 0; i < 4; i++) begin
      drive_req(wes[i], f3s[i], as[i], 32'h5A5A5A5A, 5'd3);
      step();
      req_valid = 1'b0;
      checks++;
      if (fault !== 1'b1 || bus.mem_req !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
        errors++; $display("FAIL fault_%0d got fault=%b req=%b ready=%b busy=%b want 1 0 1 0",
          i, fault, bus.mem_req, req_ready, busy);
      end
      step();
      checks++;
      if (fault !== 1'b0 || bus.mem_req !== 1'b0) begin
        errors++; $display("FAIL fault_%0d_after got fault=%b req=%b want 0 0", i, fault, bus.mem_req);
      end
    end
  endtask

  task automatic test_stall();
    int cyc;
    int n;
    drive_req(1'b0, 3'b010, 32'h300, 32'h0, 5'd9);
    step();
    req_valid = 1'b0;
    cyc = 1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.mem_req !== 1'b1 || busy !== 1'b1 || bus.mem_addr !== 32'h300 ||
          bus.mem_be !== 4'b1111 || bus.mem_we !== 1'b0) begin
        errors++; $display("FAIL stall_req_%0d got req=%b busy=%b a=%h be=%b we=%b want 1 1 00000300 1111 0",
          i, bus.mem_req, busy, bus.mem_addr, bus.mem_be, bus.mem_we);
      end
      step();
      bus.mem_rvalid = 1'b0;
      cyc++;
    end
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (busy !== 1'b1 || bus.mem_req !== 1'b0 || resp_valid !== 1'b0) begin
        errors++; $display("FAIL stall_wait_%0d got busy=%b req=%b rv=%b want 1 0 0", i, busy, bus.mem_req, resp_valid);
      end
      step();
      cyc++;
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFEF00D;
    step();
    bus.mem_rvalid = 1'b0;
    cyc++;
    n = 0;
    while (!resp_valid && n < 8) begin step(); cyc++; n++; end
    checks++;
    if (resp_valid !== 1'b1 || cyc != 8 || load_data !== 32'hCAFEF00D || rd_out !== 5'd9) begin
      errors++; $display("FAIL stall_resp got rv=%b cyc=%0d data=%h rd=%0d want 1 8 cafef00d 9",
        resp_valid, cyc, load_data, rd_out);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] data;
    logic [4:0] rdo;
    logic seen;
    drive_req(1'b1, 3'b010, 32'h400, 32'h00000001, 5'd0);
    step();
    req_valid = 1'b0;
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    checks++;
    if (store_done !== 1'b1 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_idle got sd=%b busy=%b ready=%b want 1 0 1", store_done, busy, req_ready);
    end
    run_load(3'b010, 32'h404, 32'h000055AA, 5'd12, 0, 0, lat, data, rdo, seen);
    checks++;
    if (!seen || lat != 3 || data !== 32'h000055AA || rdo !== 5'd12) begin
      errors++; $display("FAIL b2b_load got seen=%b lat=%0d data=%h rd=%0d want 1 3 000055aa 12", seen, lat, data, rdo);
    end
    step();
  endtask

  task automatic test_reset_in_wait();
    int lat;
    logic [31:0] data;
    logic [4:0] rdo;
    logic seen;
    drive_req(1'b0, 3'b010, 32'h500, 32'h0, 5'd4);
    step();
    req_valid = 1'b0;
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.mem_req !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_wait got busy=%b req=%b ready=%b want 0 0 1", busy, bus.mem_req, req_ready);
    end
    step();
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h77777777;
    step();
    bus.mem_rvalid = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_stray got rv=%b busy=%b want 0 0", resp_valid, busy);
    end
    run_load(3'b010, 32'h504, 32'h0BADC0DE, 5'd21, 0, 0, lat, data, rdo, seen);
    checks++;
    if (!seen || lat != 3 || data !== 32'h0BADC0DE || rdo !== 5'd21) begin
      errors++; $display("FAIL rst_recover got seen=%b lat=%0d data=%h rd=%0d want 1 3 0badc0de 21", seen, lat, data, rdo);
    end
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load_word();
    test_load_subword();
    test_store();
    test_fault();
    test_stall();
    test_back_to_back();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
